// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requesting datapath (master) and the
// bit-serial adder controller (slave).
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/full_adder.sv
// Single-bit combinational full adder cell, shared by the serial controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: streams operand bit pairs LSB first through one shared
// full_adder, keeping the carry in a flop between steps.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             busy;
    logic             done;

    // Adder inputs come straight from the shift-register LSBs so they never float.
    full_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The sum bits enter at the MSB end, so after WIDTH steps s_sr is aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
                    carry <= fa_carry;
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                end
                DONE: begin
                    sum_q  <= s_sr;
                    cout_q <= carry;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=16; expected
// results are queued when a start is driven and checked when done appears.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        int          edgeNum;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vecCount = 0;
    int   errCount = 0;

    exp_t q8[$];
    exp_t q16[$];
    exp_t pe8, pe16;
    bit   pend8 = 0, pend16 = 0;
    bit   prevBusy8 = 0, prevDone8 = 0, prevBusy16 = 0, prevDone16 = 0;
    int   busyCnt8 = 0, busyCnt16 = 0;

    serial_add_ctrl_if #(.WIDTH(8))  bus8 ();
    serial_add_ctrl_if #(.WIDTH(16)) bus16 ();

    serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_add_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called just after a rising edge; start is sampled at the following edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input bit both);
        logic [8:0]  r8;
        logic [16:0] r16;
        r8  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
        r16 = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.cin = cin; bus8.start = 1'b1;
        q8.push_back('{sum: {8'd0, r8[7:0]}, cout: r8[8], edgeNum: cyc + 1});
        if (both) begin
            bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.start = 1'b1;
            q16.push_back('{sum: r16[15:0], cout: r16[16], edgeNum: cyc + 1});
        end
        @(posedge clk); #1;
        bus8.start  = 1'b0;
        bus16.start = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        for (n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (q8.size() == 0 && q16.size() == 0 && !pend8 && !pend16) break;
        end
        if (n == 200) checkOutput("idle_timeout", 32'(q8.size() + q16.size()), 0);
    endtask

    task automatic waitDone8();
        int n;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus8.done) break;
        end
        if (n == 50) checkOutput("done8_timeout", 32'(bus8.done), 1);
    endtask

    // Scoreboard side for the 8-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
            pend8 = 0; prevBusy8 = 0; prevDone8 = 0; busyCnt8 = 0;
        end else begin
            if (pend8) begin
                checkOutput("sum8", 32'(bus8.sum), 32'(pe8.sum[7:0]));
                checkOutput("cout8", 32'(bus8.cout), 32'(pe8.cout));
                pend8 = 0;
            end
            if (bus8.busy && !prevBusy8 && q8.size() == 0)
                checkOutput("busy8_unrequested", 32'(bus8.busy), 0);
            if (bus8.busy) busyCnt8++;
            if (!bus8.busy && prevBusy8) begin
                checkOutput("busylen8", 32'(busyCnt8), 9);
                busyCnt8 = 0;
            end
            if (bus8.done) begin
                checkOutput("donewidth8", 32'(prevDone8), 0);
                if (q8.size() == 0) checkOutput("done8_unrequested", 32'(bus8.done), 0);
                else begin
                    pe8 = q8.pop_front();
                    checkOutput("latency8", 32'(cyc - pe8.edgeNum), 8);
                    pend8 = 1;
                end
            end
            prevBusy8 = bus8.busy;
            prevDone8 = bus8.done;
        end
    end

    // Scoreboard side for the 16-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            q16.delete();
            pend16 = 0; prevBusy16 = 0; prevDone16 = 0; busyCnt16 = 0;
        end else begin
            if (pend16) begin
                checkOutput("sum16", 32'(bus16.sum), 32'(pe16.sum));
                checkOutput("cout16", 32'(bus16.cout), 32'(pe16.cout));
                pend16 = 0;
            end
            if (bus16.busy && !prevBusy16 && q16.size() == 0)
                checkOutput("busy16_unrequested", 32'(bus16.busy), 0);
            if (bus16.busy) busyCnt16++;
            if (!bus16.busy && prevBusy16) begin
                checkOutput("busylen16", 32'(busyCnt16), 17);
                busyCnt16 = 0;
            end
            if (bus16.done) begin
                checkOutput("donewidth16", 32'(prevDone16), 0);
                if (q16.size() == 0) checkOutput("done16_unrequested", 32'(bus16.done), 0);
                else begin
                    pe16 = q16.pop_front();
                    checkOutput("latency16", 32'(cyc - pe16.edgeNum), 16);
                    pend16 = 1;
                end
            end
            prevBusy16 = bus16.busy;
            prevDone16 = bus16.done;
        end
    end

    initial begin
        rst_n = 1'b0;
        bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 1'b0;
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(bus8.busy), 0);
        checkOutput("rst_done", 32'(bus8.done), 0);
        checkOutput("rst_sum", 32'(bus8.sum), 0);
        checkOutput("rst_cout", 32'(bus8.cout), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] zero operands");
        applyStimulus(16'h00, 16'h00, 1'b0, 1'b0);
        waitIdle();

        $display("[TB] carry ripple FF+01");
        applyStimulus(16'hFF, 16'h01, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            checkOutput("carry_ripple", 32'(dut8.carry), 1);
        end
        waitIdle();

        $display("[TB] back-to-back FF+FF+1 then 5A+A5");
        applyStimulus(16'hFF, 16'hFF, 1'b1, 1'b0);
        waitDone8();
        @(posedge clk); #1;
        applyStimulus(16'h5A, 16'hA5, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("hold_sum", 32'(bus8.sum), 32'h0FF);
        checkOutput("hold_cout", 32'(bus8.cout), 1);
        repeat (4) @(negedge clk);
        checkOutput("hold_sum_late", 32'(bus8.sum), 32'h0FF);
        waitIdle();

        $display("[TB] start ignored while busy");
        applyStimulus(16'h12, 16'h34, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        waitDone8();
        bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        waitIdle();

        $display("[TB] reset mid-operation");
        applyStimulus(16'h80, 16'h80, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        checkOutput("midrst_state", 32'(dut8.state), 32'(IDLE));
        checkOutput("midrst_busy", 32'(bus8.busy), 0);
        checkOutput("midrst_sum", 32'(bus8.sum), 0);
        checkOutput("midrst_cout", 32'(bus8.cout), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        applyStimulus(16'h80, 16'h80, 1'b0, 1'b0);
        waitIdle();

        $display("[TB] random regression");
        for (int k = 0; k < 1000; k++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            waitIdle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
